lcd_write_sequencer: RTL and testbench

- Drives the 8-bit HD44780-style character LCD port (RS, RW, E, data[7:0]) directly in hardware, so the Nios II does not bit-bang display timing.
- After reset, autonomously runs the power-up wait and a fixed init command sequence.
- Then accepts command/data bytes over a valid/ready handshake and serialises each byte into a timed E-strobe write, followed by the required execution delay.
- Sits between a CPU-facing register/FIFO shim and the top-level LCD pins; write-only (busy flag never read).

---
 rtl/lcd_pkg.sv | 51 +++++
 rtl/lcd_phase_timer.sv | 31 +++
 rtl/lcd_write_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_lcd_write_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 write sequencer: state codes, init ROM,
// command constants and the long-execution command predicate.
package lcd_pkg;

   // Sequencer state codes
   typedef logic [2:0] lcd_state_t;

   localparam lcd_state_t ST_PWRUP = 3'd0;
   localparam lcd_state_t ST_LOAD  = 3'd1;
   localparam lcd_state_t ST_IDLE  = 3'd2;
   localparam lcd_state_t ST_SETUP = 3'd3;
   localparam lcd_state_t ST_EHIGH = 3'd4;
   localparam lcd_state_t ST_HOLD  = 3'd5;
   localparam lcd_state_t ST_WAIT  = 3'd6;

   // Init sequence length and index width
   localparam int INIT_LEN = 5;
   localparam int IDX_W    = 3;

   // Controller command bytes
   localparam logic [7:0] LCD_CLEAR     = 8'h01;
   localparam logic [7:0] LCD_HOME      = 8'h02;
   localparam logic [7:0] LCD_HOME_ALT  = 8'h03;  // home ignores bit 0
   localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;
   localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
   localparam logic [7:0] LCD_ENTRY_INC = 8'h06;

   // Init ROM: 8-bit/2-line function set twice, display on, clear, entry mode
   function automatic logic [7:0] init_rom_byte(input logic [IDX_W-1:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = LCD_FUNC_8B2L;
         3'd1:    b = LCD_FUNC_8B2L;
         3'd2:    b = LCD_DISP_ON;
         3'd3:    b = LCD_CLEAR;
         default: b = LCD_ENTRY_INC;
      endcase
      return b;
   endfunction

   // Clear and home need the long execution wait; data writes never do
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
      return !rs && ((b == LCD_CLEAR) || (b == LCD_HOME) || (b == LCD_HOME_ALT));
   endfunction

   // Elaboration-time maximum, used to size the phase counter
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter shared by all timed phases of the LCD sequencer.
// A phase loaded with N-1 lasts N cycles; done is high while the count is 0.
module lcd_phase_timer #(
   parameter int               CNT_W   = 8,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt;

   // Count down to zero and park there until the next load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= RST_VAL;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - ONE;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/lcd_write_sequencer.sv
// HD44780 8-bit write sequencer: power-up wait, fixed init sequence, then
// one timed E-strobe write per accepted request followed by the controller's
// execution delay. Write-only; the busy flag is never read.
// reset_reset_n is expected to be released synchronously to clk_clk.
module lcd_write_sequencer
   import lcd_pkg::*;
#(
   parameter int PWRUP_CYC = 750000,
   parameter int SETUP_CYC = 4,
   parameter int EPW_CYC   = 25,
   parameter int HOLD_CYC  = 4,
   parameter int CMD_CYC   = 2000,
   parameter int CLR_CYC   = 82000
) (
   input  logic       clk_clk,
   input  logic       reset_reset_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rs,
   input  logic [7:0] req_byte,
   input  logic       reinit,
   output logic       init_done,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [7:0] lcd_data_o,
   output logic       lcd_data_oe
);

   localparam int MAX_CYC = max_int(max_int(max_int(PWRUP_CYC, SETUP_CYC),
                                            max_int(EPW_CYC, HOLD_CYC)),
                                    max_int(CMD_CYC, CLR_CYC));
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(PWRUP_CYC - 1);
   localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] LD_EPW   = CNT_W'(EPW_CYC - 1);
   localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(CMD_CYC - 1);
   localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(CLR_CYC - 1);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INIT_LEN - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   lcd_state_t       state;
   lcd_state_t       state_nxt;
   logic [IDX_W-1:0] init_idx;
   logic             init_done_q;
   logic             req_ready_q;
   logic             e_q;
   logic             rs_q;
   logic [7:0]       data_q;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_done;

   logic             latch_rom;
   logic             latch_req;
   logic             idx_inc;
   logic             idx_clr;
   logic             set_done;
   logic             clr_done;
   logic             accept;

   // reinit has priority over a request presented in the same IDLE cycle
   assign accept = (state == ST_IDLE) && req_valid && req_ready_q && !reinit;

   lcd_phase_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (LD_PWRUP)
   ) u_timer (
      .clk      (clk_clk),
      .rst_n    (reset_reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Next-state, timer reload and side-effect strobes
   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      latch_rom = 1'b0;
      latch_req = 1'b0;
      idx_inc   = 1'b0;
      idx_clr   = 1'b0;
      set_done  = 1'b0;
      clr_done  = 1'b0;
      case (state)
         ST_PWRUP: begin
            if (tmr_done) begin
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            latch_rom = 1'b1;
            state_nxt = ST_SETUP;
            tmr_load  = 1'b1;
            tmr_val   = LD_SETUP;
         end
         ST_IDLE: begin
            if (reinit) begin
               idx_clr   = 1'b1;
               clr_done  = 1'b1;
               state_nxt = ST_PWRUP;
               tmr_load  = 1'b1;
               tmr_val   = LD_PWRUP;
            end else if (accept) begin
               latch_req = 1'b1;
               state_nxt = ST_SETUP;
               tmr_load  = 1'b1;
               tmr_val   = LD_SETUP;
            end
         end
         ST_SETUP: begin
            if (tmr_done) begin
               state_nxt = ST_EHIGH;
               tmr_load  = 1'b1;
               tmr_val   = LD_EPW;
            end
         end
         ST_EHIGH: begin
            if (tmr_done) begin
               state_nxt = ST_HOLD;
               tmr_load  = 1'b1;
               tmr_val   = LD_HOLD;
            end
         end
         ST_HOLD: begin
            if (tmr_done) begin
               state_nxt = ST_WAIT;
               tmr_load  = 1'b1;
               tmr_val   = is_long_cmd(rs_q, data_q) ? LD_CLR : LD_CMD;
            end
         end
         ST_WAIT: begin
            if (tmr_done) begin
               if (!init_done_q) begin
                  if (init_idx == LAST_IDX) begin
                     set_done  = 1'b1;
                     state_nxt = ST_IDLE;
                  end else begin
                     idx_inc   = 1'b1;
                     state_nxt = ST_LOAD;
                  end
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            state_nxt = ST_PWRUP;
            tmr_load  = 1'b1;
            tmr_val   = LD_PWRUP;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state <= ST_PWRUP;
      end else begin
         state <= state_nxt;
      end
   end

   // Init ROM index and init-complete flag
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         init_idx    <= '0;
         init_done_q <= 1'b0;
      end else begin
         if (idx_clr) begin
            init_idx <= '0;
         end else if (idx_inc) begin
            init_idx <= init_idx + IDX_ONE;
         end
         if (clr_done) begin
            init_done_q <= 1'b0;
         end else if (set_done) begin
            init_done_q <= 1'b1;
         end
      end
   end

   // RS/data latch: held from the latch edge until the execution wait ends
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         rs_q   <= 1'b0;
         data_q <= 8'h00;
      end else if (latch_rom) begin
         rs_q   <= 1'b0;
         data_q <= init_rom_byte(init_idx);
      end else if (latch_req) begin
         rs_q   <= req_rs;
         data_q <= req_byte;
      end
   end

   // E and ready are registered from the next state so both are glitch-free
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         e_q         <= 1'b0;
         req_ready_q <= 1'b0;
      end else begin
         e_q         <= (state_nxt == ST_EHIGH);
         req_ready_q <= (state_nxt == ST_IDLE);
      end
   end

   assign req_ready   = req_ready_q;
   assign init_done   = init_done_q;
   assign lcd_rs      = rs_q;
   assign lcd_rw      = 1'b0;
   assign lcd_e       = e_q;
   assign lcd_data_o  = data_q;
   assign lcd_data_oe = 1'b1;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Bench for lcd_write_sequencer: timeline model of the LCD write protocol,
// per-cycle comparison, and directed scenarios with hand-computed timings.
module tb_lcd_write_sequencer;

   localparam int P_PWR = 20;
   localparam int P_SET = 2;
   localparam int P_EPW = 3;
   localparam int P_HLD = 2;
   localparam int P_CMD = 10;
   localparam int P_CLR = 30;

   localparam int PH_PWR  = 0;
   localparam int PH_LOAD = 1;
   localparam int PH_IDLE = 2;
   localparam int PH_WR   = 3;

   logic       clk = 1'b0;
   logic       reset_reset_n;
   logic       req_valid;
   logic       req_ready;
   logic       req_rs;
   logic [7:0] req_byte;
   logic       reinit;
   logic       init_done;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_e;
   logic [7:0] lcd_data_o;
   logic       lcd_data_oe;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   // E pulse log
   int         np = 0;
   int         rise_c [64];
   int         fall_c [64];
   logic [7:0] p_data [64];
   logic       p_rs   [64];
   logic       prev_e = 1'b0;
   logic [7:0] prev_data = 8'h00;

   // Timeline model state
   int         m_ph;
   int         m_cnt;
   int         m_k;
   int         m_idx;
   int         m_done;
   logic       m_rs;
   logic [7:0] m_data;

   logic [7:0] rom [5] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
   int         exp_rise [5] = '{23, 41, 59, 77, 115};

   lcd_write_sequencer #(
      .PWRUP_CYC (P_PWR),
      .SETUP_CYC (P_SET),
      .EPW_CYC   (P_EPW),
      .HOLD_CYC  (P_HLD),
      .CMD_CYC   (P_CMD),
      .CLR_CYC   (P_CLR)
   ) dut (
      .clk_clk       (clk),
      .reset_reset_n (reset_reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_rs        (req_rs),
      .req_byte      (req_byte),
      .reinit        (reinit),
      .init_done     (init_done),
      .lcd_rs        (lcd_rs),
      .lcd_rw        (lcd_rw),
      .lcd_e         (lcd_e),
      .lcd_data_o    (lcd_data_o),
      .lcd_data_oe   (lcd_data_oe)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Total edges one write occupies after its latch edge
   function automatic int wlen(input logic rs, input logic [7:0] d);
      int w;
      w = P_SET + P_EPW + P_HLD;
      if (!rs && d >= 8'd1 && d <= 8'd3) w = w + P_CLR;
      else w = w + P_CMD;
      return w;
   endfunction

   // Model: power-up wait, one load edge per init byte, each write a fixed
   // span after its latch edge; host requests only while idle.
   initial begin
      m_ph = PH_PWR; m_cnt = 0; m_k = 0; m_idx = 0; m_done = 0;
      m_rs = 1'b0; m_data = 8'h00;
      forever begin
         @(posedge clk or negedge reset_reset_n);
         if (!reset_reset_n) begin
            m_ph = PH_PWR; m_cnt = 0; m_k = 0; m_idx = 0; m_done = 0;
            m_rs = 1'b0; m_data = 8'h00;
         end else begin
            case (m_ph)
               PH_PWR: begin
                  m_cnt++;
                  if (m_cnt == P_PWR) m_ph = PH_LOAD;
               end
               PH_LOAD: begin
                  m_rs = 1'b0; m_data = rom[m_idx]; m_k = 0; m_ph = PH_WR;
               end
               PH_IDLE: begin
                  if (reinit) begin
                     m_done = 0; m_idx = 0; m_cnt = 0; m_ph = PH_PWR;
                  end else if (req_valid) begin
                     m_rs = req_rs; m_data = req_byte; m_k = 0; m_ph = PH_WR;
                  end
               end
               default: begin
                  m_k++;
                  if (m_k == wlen(m_rs, m_data)) begin
                     if (m_done == 0) begin
                        if (m_idx == 4) begin
                           m_done = 1; m_ph = PH_IDLE;
                        end else begin
                           m_idx++; m_ph = PH_LOAD;
                        end
                     end else begin
                        m_ph = PH_IDLE;
                     end
                  end
               end
            endcase
         end
      end
   end

   // Per-cycle comparison against the model, plus E pulse logging
   initial begin
      forever begin
         @(negedge clk);
         chk("lcd_rw", int'(lcd_rw), 0);
         chk("lcd_data_oe", int'(lcd_data_oe), 1);
         chk("lcd_e", int'(lcd_e),
             int'(reset_reset_n && m_ph == PH_WR && m_k >= P_SET && m_k < P_SET + P_EPW));
         chk("req_ready", int'(req_ready), int'(reset_reset_n && m_ph == PH_IDLE));
         chk("init_done", int'(init_done), m_done);
         chk("lcd_rs", int'(lcd_rs), int'(m_rs));
         chk("lcd_data_o", int'(lcd_data_o), int'(m_data));
         if (prev_e && lcd_e) chk("data_stable_during_e", int'(lcd_data_o), int'(prev_data));
         if (lcd_e && !prev_e && np < 64) begin
            rise_c[np] = cyc; fall_c[np] = -1;
            p_data[np] = lcd_data_o; p_rs[np] = lcd_rs;
            np++;
         end
         if (!lcd_e && prev_e && np > 0) fall_c[np-1] = cyc;
         prev_e    = lcd_e;
         prev_data = lcd_data_o;
      end
   end

   // Wait for init_done and pin the init sequence timing and contents
   task automatic init_seq(input int rel, input int np0, input string tag);
      int n;
      n = 0;
      while (!init_done && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_done_edge"}, cyc - rel, 130);
      chk({tag, "_pulse_count"}, np - np0, 5);
      for (int i = 0; i < 5; i++) begin
         if (np0 + i < np) begin
            chk({tag, "_init_byte"}, int'(p_data[np0+i]), int'(rom[i]));
            chk({tag, "_init_rs"}, int'(p_rs[np0+i]), 0);
            chk({tag, "_init_rise"}, rise_c[np0+i] - rel, exp_rise[i]);
            chk({tag, "_init_epw"}, fall_c[np0+i] - rise_c[np0+i], 3);
         end
      end
   endtask

   // One host write: accept, check strobe placement and ready return latency
   task automatic wr(input logic rs, input logic [7:0] b, input int exp_lat, input string nm);
      int n;
      int t0;
      @(negedge clk);
      req_rs = rs; req_byte = b; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_ready_before"}, int'(req_ready), 1);
      @(posedge clk); #1;
      t0 = cyc;
      req_valid = 1'b0;
      chk({nm, "_ready_dropped"}, int'(req_ready), 0);
      n = 0;
      while (!req_ready && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_ready_latency"}, cyc - t0, exp_lat);
      if (np > 0) begin
         chk({nm, "_byte"}, int'(p_data[np-1]), int'(b));
         chk({nm, "_rs"}, int'(p_rs[np-1]), int'(rs));
         chk({nm, "_e_rise_after_accept"}, rise_c[np-1] - t0, 2);
         chk({nm, "_e_width"}, fall_c[np-1] - rise_c[np-1], 3);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rel;
      int np0;
      int n;
      int t0;
      int t1;

      reset_reset_n = 1'b0;
      req_valid = 1'b0; req_rs = 1'b0; req_byte = 8'h00; reinit = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_init_done", int'(init_done), 0);
      chk("rst_lcd_e", int'(lcd_e), 0);
      chk("rst_lcd_data", int'(lcd_data_o), 0);
      chk("rst_lcd_oe", int'(lcd_data_oe), 1);

      // Release with a request already pending: it must wait for init
      @(negedge clk);
      req_valid = 1'b1; req_rs = 1'b1; req_byte = 8'h55;
      reset_reset_n = 1'b1;
      rel = cyc; np0 = np;
      repeat (100) @(negedge clk);
      req_valid = 1'b0;
      init_seq(rel, np0, "init1");

      wr(1'b1, 8'h41, 17, "data_41");
      wr(1'b0, 8'h01, 37, "cmd_clear");
      wr(1'b0, 8'h80, 17, "cmd_80");
      wr(1'b0, 8'h02, 37, "cmd_home");
      wr(1'b0, 8'h03, 37, "cmd_home3");
      wr(1'b0, 8'h04, 17, "cmd_04");
      wr(1'b1, 8'h01, 17, "data_01");

      // Back-to-back with valid held
      @(negedge clk);
      req_rs = 1'b1; req_byte = 8'h48; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 500) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      t0 = cyc;
      req_byte = 8'h49;
      n = 0;
      while (!req_ready && n < 500) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      t1 = cyc;
      req_valid = 1'b0;
      chk("b2b_second_taken", int'(req_ready), 0);
      chk("b2b_accept_gap", t1 - t0, 18);
      n = 0;
      while (!req_ready && n < 500) begin @(posedge clk); #1; n++; end
      chk("b2b_ready_latency", cyc - t1, 17);
      if (np > 1) begin
         chk("b2b_first_byte", int'(p_data[np-2]), 8'h48);
         chk("b2b_second_byte", int'(p_data[np-1]), 8'h49);
      end

      // reinit while a write is in progress is ignored
      @(negedge clk);
      req_rs = 1'b1; req_byte = 8'h4A; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 500) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      t0 = cyc;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1; reinit = 1'b1;
      @(posedge clk); #1; reinit = 1'b0;
      n = 0;
      while (!req_ready && n < 500) begin @(posedge clk); #1; n++; end
      chk("busy_reinit_latency", cyc - t0, 17);
      chk("busy_reinit_done_kept", int'(init_done), 1);

      // reinit together with a request in IDLE: request dropped, init reruns
      @(negedge clk);
      reinit = 1'b1; req_valid = 1'b1; req_rs = 1'b1; req_byte = 8'h5A;
      np0 = np;
      @(posedge clk); #1;
      rel = cyc;
      reinit = 1'b0; req_valid = 1'b0;
      chk("reinit_ready_low", int'(req_ready), 0);
      chk("reinit_done_low", int'(init_done), 0);
      init_seq(rel, np0, "init2");

      // Reset asserted while E is high
      @(negedge clk);
      req_rs = 1'b1; req_byte = 8'h4B; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 500) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!lcd_e && n < 50) begin @(posedge clk); #1; n++; end
      chk("pre_reset_e_high", int'(lcd_e), 1);
      #2 reset_reset_n = 1'b0;
      #1;
      chk("async_reset_e", int'(lcd_e), 0);
      chk("async_reset_ready", int'(req_ready), 0);
      chk("async_reset_done", int'(init_done), 0);
      repeat (3) @(negedge clk);
      np0 = np;
      reset_reset_n = 1'b1;
      rel = cyc;
      init_seq(rel, np0, "init3");

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
